// File: rtl/color_pwm_driver_if.sv
// Bundles the colour-code input, enable and the LED drive/status outputs of color_pwm_driver.
interface color_pwm_driver_if #(
    parameter int PWM_W = 8,
    parameter int CNT_W = 8
);
    logic [1:0]       color;
    logic             enable;
    logic             red_pwm;
    logic             blue_pwm;
    logic [PWM_W-1:0] red_duty;
    logic [PWM_W-1:0] blue_duty;
    logic             settled;
    logic [CNT_W-1:0] change_count;

    modport master (
        output color, enable,
        input  red_pwm, blue_pwm, red_duty, blue_duty, settled, change_count
    );

    modport slave (
        input  color, enable,
        output red_pwm, blue_pwm, red_duty, blue_duty, settled, change_count
    );
endinterface

// File: rtl/color_pwm_driver.sv
// Turns the colour FSM code into two fading red/blue PWM LED drives with a change counter.
// Define COLOR_PWM_GAMMA_EN to compare the PWM counter against a squared (gamma) duty.
//
// state   | meaning
// IDLE    | dark, duties held at 0, waiting for enable
// FADING  | duties step toward their targets once every FADE_DIV cycles
// SETTLED | both duties equal their targets
module color_pwm_driver #(
    parameter int PWM_W    = 8,
    parameter int FADE_DIV = 4,
    parameter int STEP     = 16,
    parameter int CNT_W    = 8
) (
    input  logic clk,
    input  logic rst,
    color_pwm_driver_if.slave bus
);
    localparam int                 DIV_W  = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [PWM_W-1:0]   MAX    = {PWM_W{1'b1}};
    localparam logic [PWM_W:0]     STEP_V = (PWM_W + 1)'(STEP);
    localparam logic [DIV_W-1:0]   DIV_TC = DIV_W'(FADE_DIV - 1);

    typedef enum logic [1:0] {IDLE, FADING, SETTLED} state_t;

    state_t           state_q, state_d;
    logic [1:0]       color_q, color_d;
    logic [1:0]       color_prev_q, color_prev_d;
    logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [PWM_W-1:0] red_duty_q, red_duty_d;
    logic [PWM_W-1:0] blue_duty_q, blue_duty_d;
    logic [CNT_W-1:0] change_count_q, change_count_d;
    logic             red_pwm_q, red_pwm_d;
    logic             blue_pwm_q, blue_pwm_d;
    logic             settled_q, settled_d;

    logic [PWM_W-1:0] red_tgt, blue_tgt;
    logic [PWM_W-1:0] red_cmp, blue_cmp;
    logic             at_target;

    // Saturating step toward target; the up path uses one extra bit so it cannot wrap.
    function automatic logic [PWM_W-1:0] step_toward(input logic [PWM_W-1:0] duty,
                                                     input logic [PWM_W-1:0] target);
        logic [PWM_W:0]   sum;
        logic [PWM_W-1:0] diff;
        logic [PWM_W-1:0] res;
        sum  = {1'b0, duty} + STEP_V;
        diff = duty - target;
        res  = duty;
        if (duty < target) begin
            res = (sum > {1'b0, target}) ? target : sum[PWM_W-1:0];
        end else if (duty > target) begin
            res = ({1'b0, diff} <= STEP_V) ? target : duty - STEP_V[PWM_W-1:0];
        end
        return res;
    endfunction

    always_comb begin
        red_tgt  = '0;
        blue_tgt = '0;
        case (color_q)
            2'd1:    blue_tgt = MAX;
            2'd2:    red_tgt  = MAX;
            default: ;
        endcase
    end

    assign at_target = (red_duty_q == red_tgt) && (blue_duty_q == blue_tgt);

    always_comb begin
        color_d      = bus.color;
        color_prev_d = color_q;
        pwm_cnt_d    = pwm_cnt_q + PWM_W'(1);

        change_count_d = change_count_q;
        if ((color_q != color_prev_q) && (change_count_q != {CNT_W{1'b1}})) begin
            change_count_d = change_count_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        div_cnt_d   = div_cnt_q;
        red_duty_d  = red_duty_q;
        blue_duty_d = blue_duty_q;

        if (!bus.enable) begin
            state_d     = IDLE;
            div_cnt_d   = '0;
            red_duty_d  = '0;
            blue_duty_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    red_duty_d  = '0;
                    blue_duty_d = '0;
                    div_cnt_d   = '0;
                    state_d     = FADING;
                end
                FADING: begin
                    if (div_cnt_q == DIV_TC) begin
                        div_cnt_d   = '0;
                        red_duty_d  = step_toward(red_duty_q, red_tgt);
                        blue_duty_d = step_toward(blue_duty_q, blue_tgt);
                    end else begin
                        div_cnt_d = div_cnt_q + DIV_W'(1);
                    end
                    if (at_target) begin
                        state_d = SETTLED;
                    end
                end
                SETTLED: begin
                    if (!at_target) begin
                        state_d   = FADING;
                        div_cnt_d = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        settled_d = (state_d == SETTLED);
    end

`ifdef COLOR_PWM_GAMMA_EN
    logic [2*PWM_W-1:0] red_sq, blue_sq;
    assign red_sq   = {{PWM_W{1'b0}}, red_duty_q} * {{PWM_W{1'b0}}, red_duty_q};
    assign blue_sq  = {{PWM_W{1'b0}}, blue_duty_q} * {{PWM_W{1'b0}}, blue_duty_q};
    assign red_cmp  = red_sq[2*PWM_W-1:PWM_W];
    assign blue_cmp = blue_sq[2*PWM_W-1:PWM_W];
`else
    assign red_cmp  = red_duty_q;
    assign blue_cmp = blue_duty_q;
`endif

    always_comb begin
        red_pwm_d  = bus.enable && (pwm_cnt_q < red_cmp);
        blue_pwm_d = bus.enable && (pwm_cnt_q < blue_cmp);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            color_q        <= '0;
            color_prev_q   <= '0;
            pwm_cnt_q      <= '0;
            div_cnt_q      <= '0;
            red_duty_q     <= '0;
            blue_duty_q    <= '0;
            change_count_q <= '0;
            red_pwm_q      <= 1'b0;
            blue_pwm_q     <= 1'b0;
            settled_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            color_q        <= color_d;
            color_prev_q   <= color_prev_d;
            pwm_cnt_q      <= pwm_cnt_d;
            div_cnt_q      <= div_cnt_d;
            red_duty_q     <= red_duty_d;
            blue_duty_q    <= blue_duty_d;
            change_count_q <= change_count_d;
            red_pwm_q      <= red_pwm_d;
            blue_pwm_q     <= blue_pwm_d;
            settled_q      <= settled_d;
        end
    end

    assign bus.red_pwm      = red_pwm_q;
    assign bus.blue_pwm     = blue_pwm_q;
    assign bus.red_duty     = red_duty_q;
    assign bus.blue_duty    = blue_duty_q;
    assign bus.settled      = settled_q;
    assign bus.change_count = change_count_q;
endmodule
